// File: rtl/instr_fetch_queue.sv
// Fetch front end: sequential PC generation, in-order {PC, instr} queue, redirect flush.
// Optional FETCH_BYPASS_EN: forward a response straight to decode when the queue is empty.
//  state   | meaning
//  S_BOOT  | one idle cycle after reset before fetching
//  S_RUN   | issuing fetches while credit allows
//  S_FLUSH | waiting for stale in-flight responses to drain after a redirect
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    output logic                    IMemReqValid,
    output logic [31:0]             IMemReqAddr,
    input  logic                    IMemReqReady,
    input  logic                    IMemRspValid,
    input  logic [31:0]             IMemRspData,
    input  logic                    Redirect,
    input  logic [31:0]             RedirectPC,
    output logic                    InstrValid,
    output logic [31:0]             Instr,
    output logic [31:0]             PCD,
    input  logic                    InstrReady,
    output logic [$clog2(DEPTH):0]  QCount
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;

    state_t         r_state;
    logic [31:0]    r_pc;
    logic [CW-1:0]  r_outstanding;
    logic [CW-1:0]  r_discard;
    logic [CW-1:0]  r_count;
    logic [AW-1:0]  r_head;
    logic [AW-1:0]  r_tail;
    logic [AW-1:0]  r_tag_wp;
    logic [AW-1:0]  r_tag_rp;
    logic [31:0]    r_q_instr [DEPTH];
    logic [31:0]    r_q_pc    [DEPTH];
    logic [31:0]    r_tag     [DEPTH];

    logic           w_req_valid;
    logic           w_hs;
    logic           w_rsp_keep;
    logic           w_bypass;
    logic           w_push;
    logic           w_pop;
    logic [CW:0]    w_credit_used;
    logic [CW-1:0]  w_out_next;
    logic [CW-1:0]  w_inflight;
    logic [CW-1:0]  w_disc_dec;

    // Credit counts both buffered entries and fetches still in flight, so the queue cannot overflow.
    assign w_credit_used = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_req_valid   = (r_state == S_RUN) && (w_credit_used < (CW+1)'(DEPTH));
    assign w_hs          = w_req_valid && IMemReqReady;
    assign w_rsp_keep    = IMemRspValid && (r_discard == '0) && !Redirect;

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_rsp_keep && (r_count == '0);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push     = w_rsp_keep && !(w_bypass && InstrReady);
    assign w_pop      = (r_count != '0) && InstrReady && !Redirect;
    assign w_out_next = r_outstanding + CW'(w_hs) - CW'(IMemRspValid);
    assign w_inflight = r_outstanding - CW'(IMemRspValid);
    assign w_disc_dec = (IMemRspValid && (r_discard != '0)) ? (r_discard - CW'(1)) : r_discard;

    assign IMemReqValid = w_req_valid;
    assign IMemReqAddr  = {r_pc[31:2], 2'b00};
    assign QCount       = r_count;

    always_comb begin
        InstrValid = (r_count != '0);
        Instr      = InstrValid ? r_q_instr[r_head] : '0;
        PCD        = InstrValid ? r_q_pc[r_head] : '0;
        if (w_bypass) begin
            InstrValid = 1'b1;
            Instr      = IMemRspData;
            PCD        = r_tag[r_tag_rp];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_count       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_tag_wp      <= '0;
            r_tag_rp      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_instr[i] <= '0;
                r_q_pc[i]    <= '0;
                r_tag[i]     <= '0;
            end
        end else begin
            r_outstanding <= w_out_next;
            if (w_hs) begin
                r_tag[r_tag_wp] <= IMemReqAddr;
                r_tag_wp        <= r_tag_wp + AW'(1);
            end
            if (IMemRspValid) begin
                r_tag_rp <= r_tag_rp + AW'(1);
            end

            // Everything in flight after this edge belongs to the old path and must be dropped.
            if (Redirect) begin
                r_pc      <= {RedirectPC[31:2], 2'b00};
                r_discard <= w_out_next;
                r_head    <= '0;
                r_tail    <= '0;
                r_count   <= '0;
            end else begin
                if (w_hs) begin
                    r_pc <= r_pc + 32'd4;
                end
                r_discard <= w_disc_dec;
                if (w_push) begin
                    r_q_instr[r_tail] <= IMemRspData;
                    r_q_pc[r_tail]    <= r_tag[r_tag_rp];
                    r_tail            <= r_tail + AW'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + AW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end

            case (r_state)
                S_BOOT:  r_state <= S_RUN;
                S_RUN:   if (Redirect && (w_inflight != '0)) r_state <= S_FLUSH;
                S_FLUSH: if (!Redirect && (w_disc_dec == '0)) r_state <= S_RUN;
                default: r_state <= S_BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: memory model plus a transaction-level reference
// (expected request PC, path epochs, queue of expected decode entries).
module tb_instr_fetch_queue;
    localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        IMemReqValid;
    logic [31:0] IMemReqAddr;
    logic        IMemReqReady = 1'b0;
    logic        IMemRspValid = 1'b0;
    logic [31:0] IMemRspData = '0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = '0;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [31:0] PCD;
    logic        InstrReady = 1'b0;
    logic [2:0]  QCount;

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset_n(reset_n),
        .IMemReqValid(IMemReqValid), .IMemReqAddr(IMemReqAddr), .IMemReqReady(IMemReqReady),
        .IMemRspValid(IMemRspValid), .IMemRspData(IMemRspData),
        .Redirect(Redirect), .RedirectPC(RedirectPC),
        .InstrValid(InstrValid), .Instr(Instr), .PCD(PCD), .InstrReady(InstrReady),
        .QCount(QCount)
    );

    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    req_t        pend[$];
    ent_t        mq[$];
    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0, epoch = 0, hs_count = 0, delivered = 0;
    int          p_ready = 0, p_rsp = 0, p_pop = 0, p_redir = 0, lat_max = 0;
    bit          force_redir = 0, prev_stall = 0, saw_wrap = 0, grab_first = 0, got_first = 0;
    logic [31:0] force_pc = '0, exp_req_pc = '0, last_hs_addr = '0, first_pcd = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // addi-style words; address 0 gives 0x00500093, address 4 gives 0x00A00113
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [29:0] k;
        k = a[31:2] + 30'd1;
        return {12'(k * 30'd5), k[9:5], k[12:10], k[4:0], 7'h13};
    endfunction

    task automatic set_knobs(input int r, input int s, input int p, input int d, input int l);
        p_ready = r; p_rsp = s; p_pop = p; p_redir = d; lat_max = l;
    endtask

    task automatic evaluate();
        ent_t hd;
        req_t r;
        req_t nr;
        bit   has_head, keep, was_empty, consumed, hs;
        has_head  = 1'b0;
        was_empty = (mq.size() == 0);
        keep      = IMemRspValid && (pend.size() > 0) && (pend[0].epoch == epoch) && !Redirect;
        if (!was_empty) begin
            hd = mq[0];
            has_head = 1'b1;
        end else if (BYP && keep) begin
            hd.pc = pend[0].addr;
            hd.instr = mem_word(pend[0].addr);
            has_head = 1'b1;
        end
        chk("instr_valid", 32'(InstrValid), 32'(has_head));
        if (has_head) begin
            chk("pcd", PCD, hd.pc);
            chk("instr", Instr, hd.instr);
        end
        chk("qcount", 32'(QCount), 32'(mq.size()));
        if (IMemReqValid) begin
            chk("req_addr", IMemReqAddr, exp_req_pc);
            chk("req_credit", 32'(pend.size() + mq.size() < DEPTH), 32'd1);
        end
        if (prev_stall) chk("req_hold", 32'(IMemReqValid), 32'd1);

        hs = IMemReqValid && IMemReqReady;
        prev_stall = IMemReqValid && !IMemReqReady && !Redirect;
        if (InstrValid && InstrReady && !Redirect) begin
            delivered++;
            if (grab_first) begin
                first_pcd = PCD;
                got_first = 1'b1;
                grab_first = 1'b0;
            end
        end
        consumed = BYP && was_empty && keep && InstrReady;
        if (!was_empty && InstrReady && !Redirect) void'(mq.pop_front());
        if (IMemRspValid && pend.size() > 0) begin
            r = pend.pop_front();
            if (keep && !consumed) begin
                hd.pc = r.addr;
                hd.instr = mem_word(r.addr);
                mq.push_back(hd);
            end
        end
        if (hs) begin
            if (IMemReqAddr == 32'h0 && last_hs_addr == 32'hFFFF_FFFC) saw_wrap = 1'b1;
            last_hs_addr = IMemReqAddr;
            nr.addr = exp_req_pc;
            nr.epoch = epoch;
            nr.due = cyc + 1 + int'($urandom_range(lat_max));
            pend.push_back(nr);
            exp_req_pc = exp_req_pc + 32'd4;
            hs_count++;
        end
        if (Redirect) begin
            mq.delete();
            epoch++;
            exp_req_pc = {RedirectPC[31:2], 2'b00};
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        IMemReqReady = ($urandom_range(99) < p_ready);
        InstrReady   = ($urandom_range(99) < p_pop);
        if (force_redir) begin
            Redirect = 1'b1;
            RedirectPC = force_pc;
            force_redir = 1'b0;
        end else begin
            Redirect = ($urandom_range(99) < p_redir);
            case ($urandom_range(2))
                0:       RedirectPC = 32'h0000_0103;
                1:       RedirectPC = 32'hFFFF_FFF6;
                default: RedirectPC = $urandom;
            endcase
        end
        if (pend.size() > 0 && pend[0].due <= cyc && $urandom_range(99) < p_rsp) begin
            IMemRspValid = 1'b1;
            IMemRspData = mem_word(pend[0].addr);
        end else begin
            IMemRspValid = 1'b0;
            IMemRspData = $urandom;
        end
        @(negedge clk);
        evaluate();
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        force_redir = 1'b1;
        force_pc = pc;
        step();
    endtask

    task automatic reset_boot();
        reset_n = 1'b0;
        IMemReqReady = 1'b0; IMemRspValid = 1'b0; Redirect = 1'b0; InstrReady = 1'b0;
        #1;
        chk("rst_req_valid", 32'(IMemReqValid), 32'd0);
        chk("rst_req_addr", IMemReqAddr, 32'h0);
        chk("rst_instr_valid", 32'(InstrValid), 32'd0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_pcd", PCD, 32'h0);
        chk("rst_qcount", 32'(QCount), 32'd0);
        pend.delete();
        mq.delete();
        epoch++;
        exp_req_pc = 32'h0;
        prev_stall = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("boot_req_valid0", 32'(IMemReqValid), 32'd0);
        @(negedge clk);
        chk("boot_req_valid1", 32'(IMemReqValid), 32'd1);
        chk("boot_req_addr", IMemReqAddr, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0, h0, k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_boot();

        set_knobs(100, 100, 100, 0, 0);
        d0 = delivered;
        repeat (20) step();
        chk("stream_rate", 32'((delivered - d0) >= 16), 32'd1);

        set_knobs(100, 100, 0, 0, 0);
        repeat (12) step();
        chk("bp_qcount", 32'(QCount), 32'd4);
        chk("bp_req_valid", 32'(IMemReqValid), 32'd0);
        h0 = hs_count;
        p_pop = 100;
        step();
        p_pop = 0;
        repeat (5) step();
        chk("bp_one_req", 32'(hs_count - h0), 32'd1);

        set_knobs(0, 100, 100, 0, 0);
        repeat (8) step();
        set_knobs(100, 0, 100, 0, 0);
        repeat (2) step();
        p_ready = 0;
        redirect_to(32'h0000_0103);
        grab_first = 1'b1;
        got_first = 1'b0;
        p_ready = 100;
        step();
        chk("redir_flush_no_req", 32'(IMemReqValid), 32'd0);
        p_rsp = 100;
        repeat (10) step();
        chk("redir_got_first", 32'(got_first), 32'd1);
        chk("redir_first_pcd", first_pcd, 32'h0000_0100);

        set_knobs(100, 100, 0, 0, 0);
        repeat (3) step();
        p_pop = 100;
        redirect_to(32'h0000_0200);
        step();
        chk("coll_qcount", 32'(QCount), 32'd0);
        chk("coll_instr_valid", 32'(InstrValid), 32'd0);

        set_knobs(100, 100, 100, 0, 0);
        redirect_to(32'hFFFF_FFF8);
        repeat (12) step();
        chk("wrap_seen", 32'(saw_wrap), 32'd1);

        set_knobs(0, 100, 100, 0, 0);
        repeat (6) step();
        set_knobs(100, 0, 100, 0, 0);
        step();
        p_ready = 0;
        p_rsp = 100;
        step();
        chk("rsp_cycle_valid", 32'(InstrValid), 32'(BYP));
        step();
        chk("rsp_next_valid", 32'(InstrValid), 32'(!BYP));

        set_knobs(100, 100, 0, 0, 0);
        k = 0;
        while (QCount != 3'd3 && k < 20) begin
            step();
            k++;
        end
        chk("rst_setup_q3", 32'(QCount), 32'd3);
        #2;
        reset_boot();

        set_knobs(70, 70, 60, 4, 3);
        d0 = delivered;
        repeat (3000) step();
        chk("liveness", 32'((delivered - d0) > 200), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
